// File: rtl/mask_bound_extract_512bit_pkg.sv
// Shared constants and handshake state encoding for the 512-bit mask bound extractor.
// The state encoding matches the mask generator's trigger/done handshake.
package mask_bound_extract_512bit_pkg;

    localparam int MASK_W      = 512;
    localparam int CHUNK_W     = 32;
    localparam int IDX_W       = 9;
    localparam int CNT_W       = 10;
    localparam int N_CHUNKS    = MASK_W / CHUNK_W;
    localparam int CHUNK_IDX_W = 4;
    localparam int LO_W        = 5;
    localparam int PC_W        = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mask_bound_extract_512bit_if.sv
// Trigger/done request bus between an initiator and the bound extractor.
// Handshake: the initiator holds i_trig high (i_mask valid at the accepting edge) until it sees o_done;
// o_done and all result fields stay valid while i_trig stays high, and o_done drops on the first edge with i_trig low.
interface mask_bound_extract_512bit_if;
    import mask_bound_extract_512bit_pkg::*;

    logic              i_trig;
    logic [MASK_W-1:0] i_mask;
    logic              o_done;
    logic [IDX_W-1:0]  o_bound_index_left;
    logic [IDX_W-1:0]  o_bound_index_right;
    logic [CNT_W-1:0]  o_count;
    logic              o_empty;
    logic              o_contig;

    modport master (
        output i_trig, i_mask,
        input  o_done, o_bound_index_left, o_bound_index_right, o_count, o_empty, o_contig
    );

    modport slave (
        input  i_trig, i_mask,
        output o_done, o_bound_index_left, o_bound_index_right, o_count, o_empty, o_contig
    );
endinterface

// File: rtl/mask_bound_extract_512bit_chunk_encode.sv
// Combinational per-word encoder: lowest/highest set bit, popcount and nonzero flag of a 32-bit word.
module mask_chunk_encode_32bit
    import mask_bound_extract_512bit_pkg::*;
(
    input  logic [CHUNK_W-1:0] word,
    output logic [LO_W-1:0]    lo,
    output logic [LO_W-1:0]    hi,
    output logic [PC_W-1:0]    pc,
    output logic               nz
);
    always_comb begin
        lo = '0;
        hi = '0;
        pc = '0;
        // Downward scan leaves the lowest set bit in lo; upward scan leaves the highest in hi.
        for (int i = CHUNK_W - 1; i >= 0; i--) begin
            if (word[i]) lo = LO_W'(i);
        end
        for (int i = 0; i < CHUNK_W; i++) begin
            if (word[i]) hi = LO_W'(i);
            pc = pc + PC_W'(word[i]);
        end
        nz = |word;
    end
endmodule

// File: rtl/mask_bound_extract_512bit.sv
// Recovers left/right bounds, popcount, empty and contiguity of a 512-bit row mask,
// scanning one 32-bit chunk per cycle with a fixed 16-cycle latency.
module mask_bound_extract_512bit
    import mask_bound_extract_512bit_pkg::*;
(
    input  logic                        i_clk,
    input  logic                        i_rstn,
    mask_bound_extract_512bit_if.slave  bus,
    output state_t                      dbg_state
);
    state_t                 state_q, state_n;
    logic [MASK_W-1:0]      mask_q;
    logic [CHUNK_IDX_W-1:0] chunk_q;
    logic                   found_q, found_n;
    logic [IDX_W-1:0]       left_q, left_n, right_q, right_n;
    logic [CNT_W-1:0]       cnt_q, cnt_n, span_n;
    logic                   capture, scan_en, last_chunk;
    logic [LO_W-1:0]        enc_lo, enc_hi;
    logic [PC_W-1:0]        enc_pc;
    logic                   enc_nz;

    mask_chunk_encode_32bit u_encode (
        .word (mask_q[CHUNK_W-1:0]),
        .lo   (enc_lo),
        .hi   (enc_hi),
        .pc   (enc_pc),
        .nz   (enc_nz)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state_q <= ST_IDLE;
        else         state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE: if (bus.i_trig) state_n = ST_SCAN;
            ST_SCAN: if (chunk_q == CHUNK_IDX_W'(N_CHUNKS - 1)) state_n = ST_DONE;
            ST_DONE: if (!bus.i_trig) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        capture    = (state_q == ST_IDLE) && bus.i_trig;
        scan_en    = (state_q == ST_SCAN);
        last_chunk = scan_en && (chunk_q == CHUNK_IDX_W'(N_CHUNKS - 1));
        bus.o_done = (state_q == ST_DONE);
    end

    assign dbg_state = state_q;

    // Chunk k's bit position 32k+b is just {k, b}, so no adder is needed for the bounds.
    always_comb begin
        found_n = found_q | enc_nz;
        left_n  = (enc_nz && !found_q) ? {chunk_q, enc_lo} : left_q;
        right_n = enc_nz ? {chunk_q, enc_hi} : right_q;
        cnt_n   = cnt_q + CNT_W'(enc_pc);
        span_n  = CNT_W'(right_n) - CNT_W'(left_n) + 10'd1;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            mask_q  <= '0;
            chunk_q <= '0;
            found_q <= 1'b0;
            left_q  <= '0;
            right_q <= '0;
            cnt_q   <= '0;
        end else if (capture) begin
            mask_q  <= bus.i_mask;
            chunk_q <= '0;
            found_q <= 1'b0;
            left_q  <= '0;
            right_q <= '0;
            cnt_q   <= '0;
        end else if (scan_en) begin
            mask_q  <= {{CHUNK_W{1'b0}}, mask_q[MASK_W-1:CHUNK_W]};
            chunk_q <= chunk_q + 1'b1;
            found_q <= found_n;
            left_q  <= left_n;
            right_q <= right_n;
            cnt_q   <= cnt_n;
        end
    end

    // Result registers move only on the final scan edge; they hold the last result otherwise.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            bus.o_bound_index_left  <= '0;
            bus.o_bound_index_right <= '0;
            bus.o_count             <= '0;
            bus.o_empty             <= 1'b0;
            bus.o_contig            <= 1'b0;
        end else if (last_chunk) begin
            bus.o_bound_index_left  <= left_n;
            bus.o_bound_index_right <= right_n;
            bus.o_count             <= cnt_n;
            bus.o_empty             <= !found_n;
            bus.o_contig            <= found_n && (cnt_n == span_n);
        end
    end
endmodule

// File: tb/tb_mask_bound_extract_512bit.sv
// Randomized scoreboard bench for mask_bound_extract_512bit against a bit-level reference model.
module tb_mask_bound_extract_512bit;
    import mask_bound_extract_512bit_pkg::*;

    logic   i_clk;
    logic   i_rstn;
    state_t dbg_state;
    int     n_checks = 0;
    int     n_errors = 0;
    logic [29:0] exp_q[$];
    logic   prev_done = 1'b0;

    mask_bound_extract_512bit_if bus();

    mask_bound_extract_512bit dut (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got hang required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [29:0] model(input logic [511:0] m);
        int l = -1, r = -1, c = 0;
        for (int i = 0; i < 512; i++) begin
            if (m[i]) begin
                if (l < 0) l = i;
                r = i;
                c++;
            end
        end
        if (c == 0) return {9'd0, 9'd0, 10'd0, 1'b1, 1'b0};
        return {9'(l), 9'(r), 10'(c), 1'b0, (c == r - l + 1)};
    endfunction

    // Mask generator stand-in: bits l..r set.
    function automatic logic [511:0] gen_mask(input int l, input int r);
        logic [511:0] m = '0;
        for (int i = 0; i < 512; i++) m[i] = (i >= l && i <= r);
        return m;
    endfunction

    function automatic logic [511:0] rand_mask();
        logic [511:0] m = '0;
        int mode = $urandom_range(0, 3);
        case (mode)
            0: for (int i = 0; i < 16; i++) m[i*32 +: 32] = $urandom();
            1: begin
                int a = $urandom_range(0, 511);
                int b = $urandom_range(0, 511);
                m = (a < b) ? gen_mask(a, b) : gen_mask(b, a);
            end
            2: for (int i = 0; i < 4; i++) m[$urandom_range(0, 511)] = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // drop_at>0: i_trig falls after edge E<drop_at>; otherwise held hold_extra edges into DONE.
    task automatic do_req(input logic [511:0] m, input int drop_at, input bit scramble,
                          input int hold_extra);
        int lat = -1;
        exp_q.push_back(model(m));
        @(posedge i_clk); #2;
        bus.i_mask = m;
        bus.i_trig = 1'b1;
        @(posedge i_clk);
        #2;
        if (scramble) bus.i_mask = rand_mask() ^ m ^ {512{1'b1}};
        for (int e = 1; e <= 40 && lat < 0; e++) begin
            @(posedge i_clk); #1;
            if (bus.o_done) lat = e;
            if (e == drop_at) bus.i_trig = 1'b0;
        end
        check("latency", 32'(lat), 32'd16);
        if (drop_at > 0) begin
            @(posedge i_clk); #1;
            check("pulse_done_low", 32'(bus.o_done), 32'd0);
        end else begin
            repeat (hold_extra) @(posedge i_clk);
            #1;
            check("done_held", 32'(bus.o_done), 32'd1);
            bus.i_trig = 1'b0;
            @(posedge i_clk); #1;
            check("done_release", 32'(bus.o_done), 32'd0);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_done"},   32'(bus.o_done), 32'd0);
        check({tag, "_left"},   32'(bus.o_bound_index_left), 32'd0);
        check({tag, "_right"},  32'(bus.o_bound_index_right), 32'd0);
        check({tag, "_count"},  32'(bus.o_count), 32'd0);
        check({tag, "_empty"},  32'(bus.o_empty), 32'd0);
        check({tag, "_contig"}, 32'(bus.o_contig), 32'd0);
        check({tag, "_state"},  32'(dbg_state), 32'(ST_IDLE));
    endtask

    task automatic reset_mid_scan(input logic [511:0] m);
        @(posedge i_clk); #2;
        bus.i_mask = m;
        bus.i_trig = 1'b1;
        @(posedge i_clk);
        repeat (8) @(posedge i_clk);
        #1 i_rstn = 1'b0;
        #1 check_zero_outputs("midscan_reset");
        bus.i_trig = 1'b0;
        @(negedge i_clk);
        i_rstn = 1'b1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge i_clk) begin
        if (bus.o_done && !prev_done) begin
            logic [29:0] act;
            act = {bus.o_bound_index_left, bus.o_bound_index_right, bus.o_count,
                   bus.o_empty, bus.o_contig};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_result: got l=%0d r=%0d c=%0d required no result",
                         act[29:21], act[20:12], act[11:2]);
            end else begin
                logic [29:0] exp;
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    n_errors++;
                    $display("FAIL result: got l=%0d r=%0d c=%0d e=%0b k=%0b required l=%0d r=%0d c=%0d e=%0b k=%0b",
                             act[29:21], act[20:12], act[11:2], act[1], act[0],
                             exp[29:21], exp[20:12], exp[11:2], exp[1], exp[0]);
                end
            end
        end
        prev_done <= bus.o_done;
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [511:0] m;
        i_rstn     = 1'b0;
        bus.i_trig = 1'b0;
        bus.i_mask = '0;
        repeat (3) @(posedge i_clk);
        #1 check_zero_outputs("reset");
        @(negedge i_clk);
        i_rstn = 1'b1;

        do_req(gen_mask(1, 509), 0, 1'b0, 2);
        do_req('0, 0, 1'b0, 0);
        do_req({512{1'b1}}, 0, 1'b0, 1);
        m = '0; m[511] = 1'b1;
        do_req(m, 0, 1'b0, 0);
        m = '0; m[0] = 1'b1;
        do_req(m, 0, 1'b0, 0);
        m = gen_mask(3, 10); m[100] = 1'b1;
        do_req(m, 0, 1'b0, 0);
        do_req(gen_mask(31, 32), 0, 1'b0, 0);
        do_req(gen_mask(40, 300), 5, 1'b0, 0);
        do_req(gen_mask(64, 95), 0, 1'b1, 0);
        do_req(gen_mask(7, 450), 0, 1'b0, 12);

        reset_mid_scan(gen_mask(10, 20));
        do_req(gen_mask(17, 222), 0, 1'b0, 0);

        do_req(gen_mask(1, 509), 0, 1'b0, 0);
        do_req(gen_mask(0, 511), 0, 1'b0, 0);
        do_req(gen_mask(200, 200), 0, 1'b0, 0);

        for (int n = 0; n < 24; n++) begin
            int drop;
            drop = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 15)) : 0;
            do_req(rand_mask(), drop, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        repeat (30) @(posedge i_clk);
        #1 check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
